// File: rtl/gcm_pkg.sv
// Shared GCM definitions: block/length-field widths, sequencer FSM states and
// the byte-granular zero-pad mask used for partial blocks.
package gcm_pkg;

    localparam int GCM_BLK_W       = 128;
    localparam int GCM_LEN_FIELD_W = 64;
    localparam int GCM_BLK_BYTES   = GCM_BLK_W / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        WAIT   = 3'd2,
        ACCEPT = 3'd3,
        LEN    = 3'd4,
        FIN    = 3'd5
    } state_t;

    // Byte 0 is the most significant byte, so the first nbytes bytes are kept.
    function automatic logic [GCM_BLK_W-1:0] byte_mask(input logic [4:0] nbytes);
        logic [GCM_BLK_W-1:0] m;
        m = '0;
        for (int i = 0; i < GCM_BLK_BYTES; i++) begin
            if (5'(i) < nbytes) begin
                m[GCM_BLK_W-1-8*i -: 8] = 8'hff;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/gcm_ghash_seq_if.sv
// Byte-granular block stream feeding the GHASH sequencer.
// Handshake: a beat transfers on a clock edge where in_valid and in_ready are
// both high; the source holds the beat fields stable while in_valid is high
// and in_ready is low, and in_ready never depends on in_valid.
interface gcm_ghash_seq_if;
    import gcm_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [GCM_BLK_W-1:0] in_data;
    logic [4:0]           in_nbytes;
    logic                 in_is_aad;
    logic                 in_last;

    modport master (
        output in_valid, in_data, in_nbytes, in_is_aad, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_data, in_nbytes, in_is_aad, in_last,
        output in_ready
    );

endinterface

// File: rtl/gcm_blk_pad.sv
// Partial-block handling: saturating byte-count decode and zero padding of the
// bytes beyond the valid count.
module gcm_blk_pad
    import gcm_pkg::*;
(
    input  logic [GCM_BLK_W-1:0] data,
    input  logic [4:0]           nbytes,
    input  logic                 last,
    output logic [GCM_BLK_W-1:0] padded,
    output logic [4:0]           nbytes_eff,
    output logic                 bad
);

    // An empty beat is only meaningful as a message terminator; anything else
    // out of range is treated as a full block and flagged.
    always_comb begin
        bad        = (nbytes > 5'd16) || ((nbytes == 5'd0) && !last);
        nbytes_eff = bad ? 5'd16 : nbytes;
        padded     = data & byte_mask(nbytes_eff);
    end

endmodule

// File: rtl/gcm_ghash_seq.sv
// Sequencer in front of gcm_ghash: pads and feeds AAD/ciphertext blocks, tracks
// bit lengths, appends the length block and returns S with a done pulse.
module gcm_ghash_seq
    import gcm_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [GCM_BLK_W-1:0] h_in,
    gcm_ghash_seq_if.slave       in_if,
    output logic                 ghash_init,
    output logic                 ghash_next,
    output logic [GCM_BLK_W-1:0] ghash_h0,
    output logic [GCM_BLK_W-1:0] ghash_x,
    input  logic [GCM_BLK_W-1:0] ghash_y,
    input  logic                 ghash_ready,
    output logic [GCM_BLK_W-1:0] s_out,
    output logic                 done,
    output logic                 busy,
    output logic                 err,
    output state_t               dbg_state
);

    state_t state_q, state_d;
    state_t ret_q, ret_d;

    logic [GCM_BLK_W-1:0] h_q, h_d;
    logic [GCM_BLK_W-1:0] x_q, x_d;
    logic [GCM_BLK_W-1:0] s_q, s_d;
    logic                 init_q, init_d;
    logic                 next_q, next_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 seen_ct_q, seen_ct_d;
    logic [LEN_W-1:0]     len_a_q, len_a_d;
    logic [LEN_W-1:0]     len_c_q, len_c_d;

    logic [GCM_BLK_W-1:0] pad_data;
    logic [4:0]           pad_nbytes;
    logic                 pad_bad;
    logic                 empty_last;
    logic [LEN_W-1:0]     beat_bits;

    gcm_blk_pad u_pad (
        .data       (in_if.in_data),
        .nbytes     (in_if.in_nbytes),
        .last       (in_if.in_last),
        .padded     (pad_data),
        .nbytes_eff (pad_nbytes),
        .bad        (pad_bad)
    );

    assign empty_last = in_if.in_last && (in_if.in_nbytes == 5'd0);
    assign beat_bits  = LEN_W'({pad_nbytes, 3'b000});

    assign in_if.in_ready = (state_q == ACCEPT);

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        h_d       = h_q;
        x_d       = x_q;
        s_d       = s_q;
        init_d    = 1'b0;
        next_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        seen_ct_d = seen_ct_q;
        len_a_d   = len_a_q;
        len_c_d   = len_c_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    h_d       = h_in;
                    len_a_d   = '0;
                    len_c_d   = '0;
                    err_d     = 1'b0;
                    seen_ct_d = 1'b0;
                    state_d   = INIT;
                end
            end

            INIT: begin
                if (ghash_ready) begin
                    init_d  = 1'b1;
                    ret_d   = ACCEPT;
                    state_d = WAIT;
                end
            end

            // gcm_ghash still shows ready in the cycle its pulse is visible,
            // so ready only counts once both pulse registers have cleared.
            WAIT: begin
                if (!init_q && !next_q && ghash_ready) begin
                    state_d = ret_q;
                end
            end

            ACCEPT: begin
                if (in_if.in_valid) begin
                    if (empty_last) begin
                        state_d = LEN;
                    end else begin
                        x_d     = pad_data;
                        next_d  = 1'b1;
                        ret_d   = in_if.in_last ? LEN : ACCEPT;
                        state_d = WAIT;
                        if (pad_bad) begin
                            err_d = 1'b1;
                        end
                        if (in_if.in_is_aad) begin
                            len_a_d = len_a_q + beat_bits;
                            if (seen_ct_q) begin
                                err_d = 1'b1;
                            end
                        end else begin
                            len_c_d   = len_c_q + beat_bits;
                            seen_ct_d = 1'b1;
                        end
                    end
                end
            end

            LEN: begin
                if (ghash_ready) begin
                    x_d     = {GCM_LEN_FIELD_W'(len_a_q), GCM_LEN_FIELD_W'(len_c_q)};
                    next_d  = 1'b1;
                    ret_d   = FIN;
                    state_d = WAIT;
                end
            end

            FIN: begin
                s_d     = ghash_y;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q       <= '0;
            x_q       <= '0;
            s_q       <= '0;
            init_q    <= 1'b0;
            next_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            seen_ct_q <= 1'b0;
            len_a_q   <= '0;
            len_c_q   <= '0;
        end else begin
            h_q       <= h_d;
            x_q       <= x_d;
            s_q       <= s_d;
            init_q    <= init_d;
            next_q    <= next_d;
            done_q    <= done_d;
            err_q     <= err_d;
            seen_ct_q <= seen_ct_d;
            len_a_q   <= len_a_d;
            len_c_q   <= len_c_d;
        end
    end

    assign ghash_init = init_q;
    assign ghash_next = next_q;
    assign ghash_h0   = h_q;
    assign ghash_x    = x_q;
    assign s_out      = s_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule

// File: doc/gcm_ghash_seq.md
Name: gcm_ghash_seq

Overview:
- Upstream sequencer for gcm_ghash. Accepts a byte-granular stream of AAD blocks followed by ciphertext blocks.
- Zero-pads partial final blocks and accumulates the bit lengths of A and C.
- Drives the gcm_ghash init/next handshake one block at a time, then appends the len(A)||len(C) block.
- Returns S = GHASH_H(A, C) to the tag stage with a done pulse.

Parameters:
- LEN_W, 64: width of each internal bit-length counter, 4..64. Counters wrap mod 2^LEN_W and are zero-extended into their 64-bit field of the length block.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle pulse, begins a new message; ignored while busy=1
- h_in  in  128  hash subkey H; sampled on accepted start
- in_valid  in  1  data beat valid
- in_ready  out  1  data beat accepted when in_valid & in_ready
- in_data  in  128  block; byte 0 = in_data[127:120] (GCM big-endian)
- in_nbytes  in  5  valid bytes in beat, 1..16; 0 legal only with in_last
- in_is_aad  in  1  1 = AAD beat, 0 = ciphertext beat
- in_last  in  1  final beat of message
- ghash_init  out  1  one-cycle pulse to gcm_ghash.init
- ghash_next  out  1  one-cycle pulse to gcm_ghash.next
- ghash_h0  out  128  registered H to gcm_ghash.h0
- ghash_x  out  128  registered block to gcm_ghash.x; stable from pulse until ghash_ready returns high
- ghash_y  in  128  gcm_ghash.y
- ghash_ready  in  1  gcm_ghash.ready
- s_out  out  128  final GHASH value; held until next accepted start
- done  out  1  one-cycle pulse, s_out valid
- busy  out  1  high from accepted start until done
- err  out  1  sticky protocol error, cleared on accepted start

Behaviour:
- Reset values: every output and all internal state are 0; FSM = IDLE. Reset mid-message aborts with no done pulse.
- FSM states: IDLE, INIT, WAIT, ACCEPT, LEN, FIN.
- IDLE: start=1 captures h_in, clears len_a/len_c/err/seen_ct/last_seen, sets busy=1, goes to INIT.
- INIT: waits for ghash_ready=1. Pulses ghash_init with ghash_h0=H, then goes to WAIT, returning to ACCEPT.
- ACCEPT: in_ready=1 only in this state.
- On accepted beat with nbytes=n, 1..16:
  - ghash_x = in_data with bytes n..15 forced to 0; ghash_next pulses the same cycle the registers load.
  - len_a (is_aad) or len_c (else) += 8*n.
  - Goes to WAIT, returning to LEN if in_last, else ACCEPT.
- Accepted beat with in_last=1 and nbytes=0: no ghash_next, no length change; goes directly to LEN.
- WAIT: ignores ghash_ready in the cycle immediately after any pulse (gcm_ghash drops ready one cycle late), then waits for ghash_ready=1.
- LEN: issues ghash_next with ghash_x = {64'(len_a), 64'(len_c)}, then goes to WAIT returning to FIN.
- FIN: s_out <= ghash_y; done=1 for one cycle; busy=0; goes to IDLE.
- Ordering rules:
  - A ciphertext beat sets seen_ct.
  - An AAD beat after seen_ct sets err=1; the beat is still hashed and counted as AAD.
  - nbytes=0 without in_last, or nbytes>16, sets err=1; the beat is treated as 16 bytes.
- start while busy: ignored, no err.
- in_valid in IDLE/INIT/WAIT/LEN: not accepted, no effect.
- Latency:
  - Accepted start -> ghash_init is 1 cycle when ghash_ready=1.
  - Accepted beat -> ghash_next is the same edge (registered output asserted the next cycle).
  - Last ghash_ready rise -> done is 2 cycles.
- Throughput: one block per gcm_ghash latency + 2 cycles.

Decomposition:
- Shared package gcm_pkg: GCM_BLK_W=128, GCM_LEN_FIELD_W=64, FSM state enum, function byte_mask(nbytes) returning the 128-bit zero-pad mask.
- One natural sub-module: gcm_blk_pad (combinational mask/pad plus saturating nbytes decode), reusable by the CTR stage for partial-block handling.
- Length counters and FSM stay in gcm_ghash_seq.

Test Plan:
- NIST TC1, empty A and C: start, H=66e94bd4ef8a2c3b884cfa59ca342b2e, one beat {in_last=1, nbytes=0} -> exactly one ghash_next with x=0; s_out=0; done pulses once; err=0.
- NIST TC2: same H, one CT beat 0388dace60b6a392f328c2b971b2fe78, nbytes=16, last -> length block 0000000000000000_0000000000000080; s_out=f38cbb1ad69223dcc3457ae5b6b0f885.
- Partial padding: AAD beat nbytes=5, data=ffff…ff -> ghash_x=ffffffffff0000000000000000000000; len_a=40; length block high half 0x28.
- Ordering error: CT beat then AAD beat -> err=1 after the second beat; both blocks still hashed; done still occurs; next start clears err.
- Handshake/backpressure: gcm_ghash model with 9-cycle ready-low windows, in_valid held high continuously -> in_ready only in ACCEPT; no pulse while ghash_ready=0; ghash_x stable throughout each window.
- Reset mid-message: assert reset_n=0 during WAIT of the 3rd block -> all outputs 0 immediately; a fresh TC2 run afterwards gives the TC2 result; start pulsed while busy is ignored.
